// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks the destination register and Tnew of the instructions in E, M and W.
//   It checks them against the D-stage sources and their Tuse, and produces:
//   - the F/D stall, and
//   - the bypass selects for the D read ports, the E operand muxes and the
//     M store-data mux.
//   All outputs are combinational from the tracked entries and the D inputs.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   D_valid                       D holds a real instruction (0 = bubble)
//   D_rs, D_rt                    D source registers
//   D_rs_tuse, D_rt_tuse          cycles from D until each source is needed
//   D_we, D_wreg, D_tnew          D write enable, destination, Tnew on entry to E
//   stall                         hold F/D and insert a bubble into E
//   s_D_rs_data, s_D_rt_data      D read-port bypass selects
//   s_E_rs_data, s_E_rt_data      E operand forwarding selects
//   s_M_rt_data                   M store-data forwarding select
//
// Select codes
//   000 ODATA   001 EDATA   010 MDATA   011 WDATA   100 WWDATA (GRF write-through)
module hazard_scoreboard #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          D_valid,
  input  logic [4:0]    D_rs,
  input  logic [4:0]    D_rt,
  input  logic [TW-1:0] D_rs_tuse,
  input  logic [TW-1:0] D_rt_tuse,
  input  logic          D_we,
  input  logic [4:0]    D_wreg,
  input  logic [TW-1:0] D_tnew,
  output logic          stall,
  output logic [2:0]    s_D_rs_data,
  output logic [2:0]    s_D_rt_data,
  output logic [2:0]    s_E_rs_data,
  output logic [2:0]    s_E_rt_data,
  output logic [2:0]    s_M_rt_data
);

  localparam logic [2:0] SEL_ODATA  = 3'b000;
  localparam logic [2:0] SEL_EDATA  = 3'b001;
  localparam logic [2:0] SEL_MDATA  = 3'b010;
  localparam logic [2:0] SEL_WDATA  = 3'b011;
  localparam logic [2:0] SEL_WWDATA = 3'b100;

  // Only the fields that something downstream reads are kept:
  // - rs is only needed while the instruction is in E.
  // - rt is needed in E and in M (store data).
  logic          e_vld_r, e_we_r;
  logic [4:0]    e_wreg_r, e_rs_r, e_rt_r;
  logic [TW-1:0] e_tnew_r;
  logic          m_vld_r, m_we_r;
  logic [4:0]    m_wreg_r, m_rt_r;
  logic [TW-1:0] m_tnew_r;
  logic          w_vld_r, w_we_r;
  logic [4:0]    w_wreg_r;
  logic [TW-1:0] w_tnew_r;

  // A stage "writes r" only for a real, writing instruction.
  // $0 is never a dependency.
  function automatic logic writes(input logic vld, input logic we,
                                  input logic [4:0] wreg, input logic [4:0] r);
    return vld & we & (wreg == r) & (r != 5'd0);
  endfunction

  // Tnew counts down by one per stage and saturates at 0.
  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    logic [TW-1:0] d;
    if (t == '0) d = '0;
    else         d = t - TW'(1);
    return d;
  endfunction

  // Only the nearest producer matters.
  // An older producer of the same register is superseded by it.
  function automatic logic hazard(input logic e_hit, input logic [TW-1:0] e_tnew,
                                  input logic m_hit, input logic [TW-1:0] m_tnew,
                                  input logic [TW-1:0] tuse);
    logic h;
    if (e_hit)      h = (e_tnew > tuse);
    else if (m_hit) h = (m_tnew > tuse);
    else            h = 1'b0;
    return h;
  endfunction

  // The nearest producer decides.
  // If its value is not ready yet, read ODATA; the E/M muxes catch it later.
  function automatic logic [2:0] d_select(input logic e_hit, input logic [TW-1:0] e_tnew,
                                          input logic m_hit, input logic [TW-1:0] m_tnew,
                                          input logic w_hit, input logic [TW-1:0] w_tnew);
    logic [2:0] s;
    if (e_hit)      s = (e_tnew == '0) ? SEL_EDATA  : SEL_ODATA;
    else if (m_hit) s = (m_tnew == '0) ? SEL_MDATA  : SEL_ODATA;
    else if (w_hit) s = (w_tnew == '0) ? SEL_WWDATA : SEL_ODATA;
    else            s = SEL_ODATA;
    return s;
  endfunction

  // E operand select: use M if its result is ready, otherwise fall back to W.
  function automatic logic [2:0] e_select(input logic m_hit, input logic [TW-1:0] m_tnew,
                                          input logic w_hit);
    logic [2:0] s;
    if (m_hit && (m_tnew == '0)) s = SEL_MDATA;
    else if (w_hit)              s = SEL_WDATA;
    else                         s = SEL_ODATA;
    return s;
  endfunction

  // Stall detection and forwarding select decode.
  always_comb begin
    stall       = 1'b0;
    s_D_rs_data = SEL_ODATA;
    s_D_rt_data = SEL_ODATA;
    s_E_rs_data = SEL_ODATA;
    s_E_rt_data = SEL_ODATA;
    s_M_rt_data = SEL_ODATA;

    stall = D_valid &
            (hazard(writes(e_vld_r, e_we_r, e_wreg_r, D_rs), e_tnew_r,
                    writes(m_vld_r, m_we_r, m_wreg_r, D_rs), m_tnew_r, D_rs_tuse) |
             hazard(writes(e_vld_r, e_we_r, e_wreg_r, D_rt), e_tnew_r,
                    writes(m_vld_r, m_we_r, m_wreg_r, D_rt), m_tnew_r, D_rt_tuse));

    s_D_rs_data = d_select(writes(e_vld_r, e_we_r, e_wreg_r, D_rs), e_tnew_r,
                           writes(m_vld_r, m_we_r, m_wreg_r, D_rs), m_tnew_r,
                           writes(w_vld_r, w_we_r, w_wreg_r, D_rs), w_tnew_r);
    s_D_rt_data = d_select(writes(e_vld_r, e_we_r, e_wreg_r, D_rt), e_tnew_r,
                           writes(m_vld_r, m_we_r, m_wreg_r, D_rt), m_tnew_r,
                           writes(w_vld_r, w_we_r, w_wreg_r, D_rt), w_tnew_r);

    if (e_vld_r) begin
      s_E_rs_data = e_select(writes(m_vld_r, m_we_r, m_wreg_r, e_rs_r), m_tnew_r,
                             writes(w_vld_r, w_we_r, w_wreg_r, e_rs_r));
      s_E_rt_data = e_select(writes(m_vld_r, m_we_r, m_wreg_r, e_rt_r), m_tnew_r,
                             writes(w_vld_r, w_we_r, w_wreg_r, e_rt_r));
    end else begin
      s_E_rs_data = SEL_ODATA;
      s_E_rt_data = SEL_ODATA;
    end

    if (writes(w_vld_r, w_we_r, w_wreg_r, m_rt_r)) s_M_rt_data = SEL_WDATA;
    else                                           s_M_rt_data = SEL_ODATA;
  end

  // Entry pipeline.
  // - Each entry advances one stage per cycle.
  // - A bubble clears the whole E entry, so stale register numbers never
  //   match later.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_vld_r <= 1'b0; e_we_r <= 1'b0; e_wreg_r <= 5'd0; e_tnew_r <= '0;
      e_rs_r  <= 5'd0; e_rt_r <= 5'd0;
      m_vld_r <= 1'b0; m_we_r <= 1'b0; m_wreg_r <= 5'd0; m_tnew_r <= '0;
      m_rt_r  <= 5'd0;
      w_vld_r <= 1'b0; w_we_r <= 1'b0; w_wreg_r <= 5'd0; w_tnew_r <= '0;
    end else begin
      w_vld_r  <= m_vld_r;
      w_we_r   <= m_we_r;
      w_wreg_r <= m_wreg_r;
      w_tnew_r <= dec_sat(m_tnew_r);
      m_vld_r  <= e_vld_r;
      m_we_r   <= e_we_r;
      m_wreg_r <= e_wreg_r;
      m_tnew_r <= dec_sat(e_tnew_r);
      m_rt_r   <= e_rt_r;
      if (D_valid && !stall) begin
        e_vld_r  <= 1'b1;
        e_we_r   <= D_we;
        e_wreg_r <= D_wreg;
        e_tnew_r <= D_tnew;
        e_rs_r   <= D_rs;
        e_rt_r   <= D_rt;
      end else begin
        e_vld_r  <= 1'b0;
        e_we_r   <= 1'b0;
        e_wreg_r <= 5'd0;
        e_tnew_r <= '0;
        e_rs_r   <= 5'd0;
        e_rt_r   <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          D_valid;
  logic [4:0]    D_rs, D_rt;
  logic [TW-1:0] D_rs_tuse, D_rt_tuse;
  logic          D_we;
  logic [4:0]    D_wreg;
  logic [TW-1:0] D_tnew;
  logic          stall;
  logic [2:0]    s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data, s_M_rt_data;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.TW(TW)) dut (
    .clk(clk), .rst(rst), .D_valid(D_valid),
    .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_we(D_we), .D_wreg(D_wreg), .D_tnew(D_tnew),
    .stall(stall), .s_D_rs_data(s_D_rs_data), .s_D_rt_data(s_D_rt_data),
    .s_E_rs_data(s_E_rs_data), .s_E_rt_data(s_E_rt_data), .s_M_rt_data(s_M_rt_data)
  );

  always #5 clk = ~clk;

  // Reference model: the instructions in flight, index 0 = E, 1 = M, 2 = W.
  // Tnew is derived from the entry Tnew and how many stages the instruction
  // has travelled.
  typedef struct {
    bit vld;
    bit we;
    int wreg;
    int tnew0;
    int rs;
    int rt;
  } ins_t;
  ins_t pipe[3];

  function automatic int age_tnew(int i);
    int t;
    t = pipe[i].tnew0 - i;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit wr(int i, int r);
    return pipe[i].vld && pipe[i].we && (pipe[i].wreg == r) && (r != 0);
  endfunction

  function automatic bit exp_stall();
    bit s;
    int srcs[2];
    int tus[2];
    s = 0;
    srcs[0] = int'(D_rs);
    srcs[1] = int'(D_rt);
    tus[0]  = int'(D_rs_tuse);
    tus[1]  = int'(D_rt_tuse);
    if (!D_valid) return 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 2; i++)
        if (wr(i, srcs[k])) begin
          if (age_tnew(i) > tus[k]) s = 1;
          break;
        end
    return s;
  endfunction

  function automatic logic [2:0] exp_dsel(int r);
    for (int i = 0; i < 3; i++)
      if (wr(i, r)) begin
        if (age_tnew(i) != 0) return 3'd0;
        return (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : 3'd4;
      end
    return 3'd0;
  endfunction

  function automatic logic [2:0] exp_esel(int r);
    if (!pipe[0].vld) return 3'd0;
    if (wr(1, r) && age_tnew(1) == 0) return 3'd2;
    if (wr(2, r)) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [2:0] exp_msel();
    return wr(2, pipe[1].rt) ? 3'd3 : 3'd0;
  endfunction

  task automatic set_d(input bit v, input int rs, input int rt, input int rs_tu, input int rt_tu,
                       input bit we, input int wreg, input int tnew);
    D_valid   = v;
    D_rs      = 5'(rs);
    D_rt      = 5'(rt);
    D_rs_tuse = TW'(rs_tu);
    D_rt_tuse = TW'(rt_tu);
    D_we      = we;
    D_wreg    = 5'(wreg);
    D_tnew    = TW'(tnew);
    #1;
  endtask

  // One clock: the model advances on the same edge as the DUT, then the
  // bench returns to the falling edge to drive/sample.
  task automatic step();
    bit st_now;
    st_now = exp_stall();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0};
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (D_valid && !st_now)
        pipe[0] = '{1, D_we, int'(D_wreg), int'(D_tnew), int'(D_rs), int'(D_rt)};
      else
        pipe[0] = '{0, 0, 0, 0, 0, 0};
    end
    @(negedge clk);
  endtask

  task automatic flush();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (s_D_rs_data !== 3'b000) begin errors++; $display("FAIL reset_d_rs got %b want 000", s_D_rs_data); end
    checks++; if (s_D_rt_data !== 3'b000) begin errors++; $display("FAIL reset_d_rt got %b want 000", s_D_rt_data); end
    checks++; if (s_E_rs_data !== 3'b000) begin errors++; $display("FAIL reset_e_rs got %b want 000", s_E_rs_data); end
    checks++; if (s_E_rt_data !== 3'b000) begin errors++; $display("FAIL reset_e_rt got %b want 000", s_E_rt_data); end
    checks++; if (s_M_rt_data !== 3'b000) begin errors++; $display("FAIL reset_m_rt got %b want 000", s_M_rt_data); end
  endtask

  task automatic test_alu_branch();
    set_d(1, 1, 2, 1, 1, 1, 8, 1);                  // addu $8
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_first_stall got %b want 0", stall); end
    step();
    set_d(0, 8, 0, 0, 0, 0, 0, 0);                  // not valid: stall gated
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_gate_stall got %b want 0", stall); end
    set_d(1, 8, 0, 0, 0, 0, 0, 0);                  // beq $8, tuse 0
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL alu_branch_stall got %b want 1", stall); end
    step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_branch_release got %b want 0", stall); end
    checks++; if (s_D_rs_data !== 3'b010) begin errors++; $display("FAIL alu_branch_dsel got %b want 010", s_D_rs_data); end
    step();
    flush();
  endtask

  task automatic test_load_use();
    set_d(1, 29, 0, 1, 1, 1, 9, 2);                 // lw $9
    step();
    set_d(1, 9, 10, 1, 1, 1, 11, 0);                // addu rs=$9
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b want 1", stall); end
    step();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_use_release got %b want 0", stall); end
    checks++; if (s_D_rs_data !== 3'b000) begin errors++; $display("FAIL load_use_dsel got %b want 000", s_D_rs_data); end
    step();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (s_E_rs_data !== 3'b011) begin errors++; $display("FAIL load_use_esel got %b want 011", s_E_rs_data); end
    flush();
  endtask

  task automatic test_write_through();
    set_d(1, 1, 2, 1, 1, 1, 5, 0);
    step();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    set_d(1, 0, 5, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wthru_stall got %b want 0", stall); end
    checks++; if (s_D_rt_data !== 3'b100) begin errors++; $display("FAIL wthru_dsel got %b want 100", s_D_rt_data); end
    flush();
  endtask

  task automatic test_zero_priority();
    set_d(1, 1, 2, 1, 1, 1, 0, 2);                  // writes $0
    step();
    set_d(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %b want 0", stall); end
    checks++; if (s_D_rs_data !== 3'b000) begin errors++; $display("FAIL zero_dsel got %b want 000", s_D_rs_data); end
    flush();
    set_d(1, 1, 2, 1, 1, 1, 7, 0);
    step();
    set_d(1, 3, 4, 1, 1, 1, 7, 0);
    step();
    set_d(1, 7, 0, 0, 0, 0, 0, 0);
    checks++; if (s_D_rs_data !== 3'b001) begin errors++; $display("FAIL prio_dsel got %b want 001", s_D_rs_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall got %b want 0", stall); end
    flush();
  endtask

  task automatic test_store_data();
    set_d(1, 29, 0, 1, 1, 1, 4, 2);                 // lw $4
    step();
    set_d(1, 29, 4, 1, 2, 0, 0, 0);                 // sw rt=$4, rt_tuse 2
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_stall got %b want 0", stall); end
    step();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if (s_M_rt_data !== 3'b011) begin errors++; $display("FAIL store_msel got %b want 011", s_M_rt_data); end
    flush();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_d($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 2));
      checks++; if (stall !== exp_stall()) begin errors++; $display("FAIL rnd_stall n=%0d got %b want %b", n, stall, exp_stall()); end
      checks++; if (s_D_rs_data !== exp_dsel(int'(D_rs))) begin errors++; $display("FAIL rnd_d_rs n=%0d got %b want %b", n, s_D_rs_data, exp_dsel(int'(D_rs))); end
      checks++; if (s_D_rt_data !== exp_dsel(int'(D_rt))) begin errors++; $display("FAIL rnd_d_rt n=%0d got %b want %b", n, s_D_rt_data, exp_dsel(int'(D_rt))); end
      checks++; if (s_E_rs_data !== exp_esel(pipe[0].rs)) begin errors++; $display("FAIL rnd_e_rs n=%0d got %b want %b", n, s_E_rs_data, exp_esel(pipe[0].rs)); end
      checks++; if (s_E_rt_data !== exp_esel(pipe[0].rt)) begin errors++; $display("FAIL rnd_e_rt n=%0d got %b want %b", n, s_E_rt_data, exp_esel(pipe[0].rt)); end
      checks++; if (s_M_rt_data !== exp_msel()) begin errors++; $display("FAIL rnd_m_rt n=%0d got %b want %b", n, s_M_rt_data, exp_msel()); end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0};
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_alu_branch();
    test_load_use();
    test_write_through();
    test_zero_priority();
    test_store_data();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
